// File: rtl/multicycle_control_pkg.sv
// Shared control definitions for the RV64 subset controllers (single-cycle and multicycle).
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_HALT     = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    SRCB_RS2     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH1 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle sequencer (master) and the shared datapath (slave).
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       pc_source;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal, state
  );
endinterface

// File: rtl/multicycle_control_opcode_class.sv
// Combinational opcode classifier; exactly one output is high for any opcode.
module mc_opcode_class
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_is_r,
  output logic       o_is_ld,
  output logic       o_is_sd,
  output logic       o_is_beq,
  output logic       o_is_bad
);
  assign o_is_r   = (i_opcode == OP_R);
  assign o_is_ld  = (i_opcode == OP_LD);
  assign o_is_sd  = (i_opcode == OP_SD);
  assign o_is_beq = (i_opcode == OP_BEQ);
  assign o_is_bad = ~(o_is_r | o_is_ld | o_is_sd | o_is_beq);
endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer for R-type/ld/sd/beq: one datapath phase per cycle, memory stalls via mem_ready.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_control_if.master  bus
);

  state_t     r_state;
  state_t     w_next;
  logic       w_is_r, w_is_ld, w_is_sd, w_is_beq, w_is_bad;
  logic       w_pc_write, w_branch, w_iord, w_mem_read, w_mem_write, w_ir_write;
  logic       w_mem_to_reg, w_reg_write, w_alu_src_a, w_pc_source, w_instr_done, w_illegal;
  alu_src_b_t w_alu_src_b;
  alu_op_t    w_alu_op;

  mc_opcode_class u_class (
    .i_opcode (bus.opcode),
    .o_is_r   (w_is_r),
    .o_is_ld  (w_is_ld),
    .o_is_sd  (w_is_sd),
    .o_is_beq (w_is_beq),
    .o_is_bad (w_is_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_RS2;
    w_alu_op     = ALUOP_ADD;
    w_pc_source  = 1'b0;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively form the branch target while the opcode is classified.
        w_alu_src_b = SRCB_IMM_SH1;
        if (w_is_bad) begin
          if (HALT_ON_ILLEGAL) begin
            w_next = S_HALT;
          end else begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        end else if (w_is_ld || w_is_sd) w_next = S_MEMADR;
        else if (w_is_r)                 w_next = S_EXECUTE;
        else                             w_next = S_BRANCH;
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        if (w_is_ld)      w_next = S_MEMREAD;
        else if (w_is_sd) w_next = S_MEMWRITE;
        else              w_next = S_FETCH;
      end
      S_MEMREAD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (bus.mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (bus.mem_ready) begin
          w_instr_done = 1'b1;
          w_next       = S_FETCH;
        end
      end
      S_EXECUTE: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALUOP_FUNCT;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = ALUOP_SUB;
        w_pc_source  = 1'b1;
        w_branch     = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_HALT: begin
        w_illegal = 1'b1;
        w_next    = S_HALT;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Every output is forced low while reset is held, so an abort drops requests at once.
  assign bus.pc_en      = rst_n & (w_pc_write | (w_branch & bus.zero));
  assign bus.iord       = rst_n & w_iord;
  assign bus.mem_read   = rst_n & w_mem_read;
  assign bus.mem_write  = rst_n & w_mem_write;
  assign bus.ir_write   = rst_n & w_ir_write;
  assign bus.mem_to_reg = rst_n & w_mem_to_reg;
  assign bus.reg_write  = rst_n & w_reg_write;
  assign bus.alu_src_a  = rst_n & w_alu_src_a;
  assign bus.alu_src_b  = rst_n ? w_alu_src_b : SRCB_RS2;
  assign bus.alu_op     = rst_n ? w_alu_op : ALUOP_ADD;
  assign bus.pc_source  = rst_n & w_pc_source;
  assign bus.instr_done = rst_n & w_instr_done;
  assign bus.illegal    = rst_n & w_illegal;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Lockstep bench for both HALT_ON_ILLEGAL settings against an instruction-level state-trace model.
module tb_multicycle_control;
  import riscv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_control_if bh ();
  multicycle_control_if bs ();

  multicycle_control #(.HALT_ON_ILLEGAL(1'b1)) dut_h (.clk(clk), .rst_n(rst_n), .bus(bh.master));
  multicycle_control #(.HALT_ON_ILLEGAL(1'b0)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs.master));

  wire [14:0] h_out = {bh.pc_en, bh.iord, bh.mem_read, bh.mem_write, bh.ir_write, bh.mem_to_reg,
                       bh.reg_write, bh.alu_src_a, bh.alu_src_b, bh.alu_op, bh.pc_source,
                       bh.instr_done, bh.illegal};
  wire [14:0] s_out = {bs.pc_en, bs.iord, bs.mem_read, bs.mem_write, bs.ir_write, bs.mem_to_reg,
                       bs.reg_write, bs.alu_src_a, bs.alu_src_b, bs.alu_op, bs.pc_source,
                       bs.instr_done, bs.illegal};

  function automatic bit is_legal(input logic [6:0] op);
    return (op == 7'b0110011) || (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b1100011);
  endfunction

  // Expected control word for one cycle, from the per-phase control table.
  function automatic logic [14:0] exp_out(input int st, input logic [6:0] op, input logic z,
                                          input logic r, input bit halt);
    logic pc_en = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rw = 0, a = 0;
    logic ps = 0, done = 0, ill = 0;
    logic [1:0] b = 2'b00, aop = 2'b00;
    case (st)
      0: begin mrd = 1; b = 2'b01; irw = r; pc_en = r; end
      1: begin b = 2'b11; ill = !halt && !is_legal(op); end
      2: begin a = 1; b = 2'b10; end
      3: begin mrd = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; done = 1; end
      5: begin mwr = 1; iord = 1; done = r; end
      6: begin a = 1; aop = 2'b10; end
      7: begin rw = 1; done = 1; end
      8: begin a = 1; aop = 2'b01; ps = 1; pc_en = z; done = 1; end
      9: ill = 1;
      default: ;
    endcase
    return {pc_en, iord, mrd, mwr, irw, m2r, rw, a, b, aop, ps, done, ill};
  endfunction

  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic z, input logic r);
    bh.opcode = op; bs.opcode = op;
    bh.zero = z;    bs.zero = z;
    bh.mem_ready = r; bs.mem_ready = r;
  endtask

  // Hold reset for two cycles with mem_ready high; rst_n is released by the next instruction.
  task automatic do_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst_n = 1'b0;
      drive(7'($urandom), 1'b1, 1'b1);
      #1;
      check({tag, "_h_state"}, {11'd0, bh.state}, 15'd0);
      check({tag, "_h_out"}, h_out, 15'd0);
      check({tag, "_s_state"}, {11'd0, bs.state}, 15'd0);
      check({tag, "_s_out"}, s_out, 15'd0);
    end
  endtask

  // Build the expected state trace of one instruction, then step it cycle by cycle.
  task automatic run_instr(input string tag, input logic [6:0] op, input int fw, input int mw,
                           input logic z, input int abort);
    int qh[$], qs[$];
    logic qr[$], qz[$];
    logic [6:0] qo[$];
    for (int k = 0; k < fw; k++) begin
      qh.push_back(0); qs.push_back(0); qr.push_back(1'b0); qz.push_back(1'($urandom)); qo.push_back(7'($urandom));
    end
    qh.push_back(0); qs.push_back(0); qr.push_back(1'b1); qz.push_back(1'($urandom)); qo.push_back(7'($urandom));
    qh.push_back(1); qs.push_back(1); qr.push_back(1'($urandom)); qz.push_back(1'($urandom)); qo.push_back(op);
    if (!is_legal(op)) begin
      for (int k = 0; k < 3; k++) begin
        qh.push_back(9); qs.push_back(0); qr.push_back(1'b0); qz.push_back(1'($urandom)); qo.push_back(op);
      end
    end else if (op == OP_R) begin
      foreach (qh[k]) ;
      qh.push_back(6); qs.push_back(6); qr.push_back(1'($urandom)); qz.push_back(1'($urandom)); qo.push_back(op);
      qh.push_back(7); qs.push_back(7); qr.push_back(1'($urandom)); qz.push_back(1'($urandom)); qo.push_back(op);
    end else if (op == OP_BEQ) begin
      qh.push_back(8); qs.push_back(8); qr.push_back(1'($urandom)); qz.push_back(z); qo.push_back(op);
    end else begin
      qh.push_back(2); qs.push_back(2); qr.push_back(1'($urandom)); qz.push_back(1'($urandom)); qo.push_back(op);
      for (int k = 0; k <= mw; k++) begin
        int st = (op == OP_LD) ? 3 : 5;
        qh.push_back(st); qs.push_back(st); qr.push_back(k == mw); qz.push_back(1'($urandom)); qo.push_back(op);
      end
      if (op == OP_LD) begin
        qh.push_back(4); qs.push_back(4); qr.push_back(1'($urandom)); qz.push_back(1'($urandom)); qo.push_back(op);
      end
    end
    for (int i = 0; i < qh.size(); i++) begin
      @(negedge clk);
      drive(qo[i], qz[i], qr[i]);
      if (i == abort) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_abort_h_state"}, {11'd0, bh.state}, 15'd0);
        check({tag, "_abort_h_out"}, h_out, 15'd0);
        check({tag, "_abort_s_mem_write"}, {14'd0, bs.mem_write}, 15'd0);
        check({tag, "_abort_s_out"}, s_out, 15'd0);
        break;
      end
      rst_n = 1'b1;
      #1;
      check({tag, "_h_state"}, {11'd0, bh.state}, 15'(qh[i]));
      check({tag, "_h_out"}, h_out, exp_out(qh[i], qo[i], qz[i], qr[i], 1'b1));
      check({tag, "_s_state"}, {11'd0, bs.state}, 15'(qs[i]));
      check({tag, "_s_out"}, s_out, exp_out(qs[i], qo[i], qz[i], qr[i], 1'b0));
    end
  endtask

  initial begin
    logic [6:0] ops [4];
    logic [6:0] op;
    ops[0] = OP_R; ops[1] = OP_LD; ops[2] = OP_SD; ops[3] = OP_BEQ;
    drive(7'd0, 1'b0, 1'b1);

    do_reset("reset");
    run_instr("rtype", OP_R, 0, 0, 1'b0, -1);
    run_instr("ld_wait2", OP_LD, 0, 2, 1'b0, -1);
    run_instr("beq_taken", OP_BEQ, 1, 0, 1'b1, -1);
    run_instr("beq_not_taken", OP_BEQ, 0, 0, 1'b0, -1);
    run_instr("sd_nowait", OP_SD, 0, 0, 1'b0, -1);
    run_instr("illegal_7f", 7'b1111111, 0, 0, 1'b0, -1);
    do_reset("reset_after_halt");
    run_instr("sd_abort", OP_SD, 0, 3, 1'b0, 4);
    do_reset("reset_after_abort");

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 7'($urandom); while (is_legal(op));
      end else begin
        op = ops[$urandom_range(0, 3)];
      end
      run_instr("rand", op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), -1);
      if (!is_legal(op)) do_reset("rand_reset");
    end

    @(negedge clk);
    drive(7'd0, 1'b0, 1'b0);
    #1;
    check("final_h_state", {11'd0, bh.state}, 15'd0);
    check("final_s_state", {11'd0, bs.state}, 15'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
